// File: rtl/alu_rs.sv
// Reservation station feeding the integer ALU: buffers renamed instructions, snoops both CDBs, issues one ready entry per cycle.
// Optional macro RS_AGE_SELECT_EN enables oldest-first selection through an age matrix; otherwise lowest index wins.
module alu_rs #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6,
    parameter int XLEN    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             issue_valid,
    input  logic [OP_W-1:0]  issue_op,
    input  logic [XLEN-1:0]  issue_pc,
    input  logic [XLEN-1:0]  issue_imm,
    input  logic [ROB_W-1:0] issue_rob_pos,
    input  logic             issue_q1_busy,
    input  logic             issue_q2_busy,
    input  logic [ROB_W-1:0] issue_q1_tag,
    input  logic [ROB_W-1:0] issue_q2_tag,
    input  logic [XLEN-1:0]  issue_v1,
    input  logic [XLEN-1:0]  issue_v2,
    input  logic             alu_cdb_valid,
    input  logic [ROB_W-1:0] alu_cdb_rob,
    input  logic [XLEN-1:0]  alu_cdb_val,
    input  logic             lsb_cdb_valid,
    input  logic [ROB_W-1:0] lsb_cdb_rob,
    input  logic [XLEN-1:0]  lsb_cdb_val,
    output logic             full,
    output logic             alu_work,
    output logic [OP_W-1:0]  alu_op,
    output logic [XLEN-1:0]  alu_pc,
    output logic [XLEN-1:0]  alu_imm,
    output logic [XLEN-1:0]  alu_rs1,
    output logic [XLEN-1:0]  alu_rs2,
    output logic [ROB_W-1:0] alu_rob_pos
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d, q1b_q, q1b_d, q2b_q, q2b_d;
    logic [OP_W-1:0]    op_q  [RS_SIZE];
    logic [OP_W-1:0]    op_d  [RS_SIZE];
    logic [XLEN-1:0]    pc_q  [RS_SIZE];
    logic [XLEN-1:0]    pc_d  [RS_SIZE];
    logic [XLEN-1:0]    imm_q [RS_SIZE];
    logic [XLEN-1:0]    imm_d [RS_SIZE];
    logic [ROB_W-1:0]   rob_q [RS_SIZE];
    logic [ROB_W-1:0]   rob_d [RS_SIZE];
    logic [ROB_W-1:0]   q1t_q [RS_SIZE];
    logic [ROB_W-1:0]   q1t_d [RS_SIZE];
    logic [ROB_W-1:0]   q2t_q [RS_SIZE];
    logic [ROB_W-1:0]   q2t_d [RS_SIZE];
    logic [XLEN-1:0]    v1_q  [RS_SIZE];
    logic [XLEN-1:0]    v1_d  [RS_SIZE];
    logic [XLEN-1:0]    v2_q  [RS_SIZE];
    logic [XLEN-1:0]    v2_d  [RS_SIZE];
`ifdef RS_AGE_SELECT_EN
    logic [RS_SIZE-1:0] age_q [RS_SIZE];
    logic [RS_SIZE-1:0] age_d [RS_SIZE];
`endif

    logic             work_q, work_d;
    logic [OP_W-1:0]  out_op_q, out_op_d;
    logic [XLEN-1:0]  out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [XLEN-1:0]  out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [ROB_W-1:0] out_rob_q, out_rob_d;

    logic [RS_SIZE-1:0] ready_s, cand_s, sel_mask_s;
    logic               free_found_s, sel_found_s;
    logic [IDX_W-1:0]   free_idx_s, sel_idx_s;

    // Returns {still_pending, value}; the ALU bus wins if both buses carry the tag.
    function automatic logic [XLEN:0] snoop(
        input logic pend, input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] val,
        input logic av, input logic [ROB_W-1:0] ar, input logic [XLEN-1:0] aval,
        input logic lv, input logic [ROB_W-1:0] lr, input logic [XLEN-1:0] lval);
        if (pend && av && (ar == tag)) begin
            return {1'b0, aval};
        end else if (pend && lv && (lr == tag)) begin
            return {1'b0, lval};
        end else begin
            return {pend, val};
        end
    endfunction

    // Ready vector, selection candidates and the free/select priority encoders.
    always_comb begin
        ready_s = busy_q & ~q1b_q & ~q2b_q;
`ifdef RS_AGE_SELECT_EN
        for (int i = 0; i < RS_SIZE; i++) begin
            cand_s[i] = ready_s[i] && ((age_q[i] & ready_s) == '0);
        end
`else
        cand_s = ready_s;
`endif
        free_found_s = 1'b0;
        free_idx_s   = '0;
        sel_found_s  = 1'b0;
        sel_idx_s    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
            if (cand_s[i]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IDX_W'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        sel_mask_s = sel_found_s ? (RS_SIZE'(1) << sel_idx_s) : '0;
    end

    // Next-state: rollback, freeze, wakeup, select and allocate.
    always_comb begin
        busy_d = busy_q; q1b_d = q1b_q; q2b_d = q2b_q;
        op_d = op_q; pc_d = pc_q; imm_d = imm_q; rob_d = rob_q;
        q1t_d = q1t_q; q2t_d = q2t_q; v1_d = v1_q; v2_d = v2_q;
`ifdef RS_AGE_SELECT_EN
        age_d = age_q;
`endif
        work_d = 1'b0;
        out_op_d = out_op_q; out_pc_d = out_pc_q; out_imm_d = out_imm_q;
        out_rs1_d = out_rs1_q; out_rs2_d = out_rs2_q; out_rob_d = out_rob_q;
        if (rollback) begin
            busy_d = '0;
        end else if (!rdy) begin
            work_d = 1'b0;
        end else begin
            // Free entries snoop too; harmless because allocation overwrites them.
            for (int i = 0; i < RS_SIZE; i++) begin
                {q1b_d[i], v1_d[i]} = snoop(q1b_q[i], q1t_q[i], v1_q[i], alu_cdb_valid, alu_cdb_rob,
                                            alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
                {q2b_d[i], v2_d[i]} = snoop(q2b_q[i], q2t_q[i], v2_q[i], alu_cdb_valid, alu_cdb_rob,
                                            alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
            end
            if (sel_found_s) begin
                busy_d[sel_idx_s] = 1'b0;
                work_d    = 1'b1;
                out_op_d  = op_q[sel_idx_s];
                out_pc_d  = pc_q[sel_idx_s];
                out_imm_d = imm_q[sel_idx_s];
                out_rs1_d = v1_q[sel_idx_s];
                out_rs2_d = v2_q[sel_idx_s];
                out_rob_d = rob_q[sel_idx_s];
            end else begin
                work_d = 1'b0;
            end
            if (issue_valid && free_found_s) begin
                busy_d[free_idx_s] = 1'b1;
                op_d[free_idx_s]   = issue_op;
                pc_d[free_idx_s]   = issue_pc;
                imm_d[free_idx_s]  = issue_imm;
                rob_d[free_idx_s]  = issue_rob_pos;
                q1t_d[free_idx_s]  = issue_q1_tag;
                q2t_d[free_idx_s]  = issue_q2_tag;
                {q1b_d[free_idx_s], v1_d[free_idx_s]} = snoop(issue_q1_busy, issue_q1_tag, issue_v1,
                    alu_cdb_valid, alu_cdb_rob, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
                {q2b_d[free_idx_s], v2_d[free_idx_s]} = snoop(issue_q2_busy, issue_q2_tag, issue_v2,
                    alu_cdb_valid, alu_cdb_rob, alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
`ifdef RS_AGE_SELECT_EN
                // Stale "older" bits pointing at the reused slot must go, or two entries could block each other.
                for (int k = 0; k < RS_SIZE; k++) begin
                    age_d[k][free_idx_s] = 1'b0;
                end
                age_d[free_idx_s] = busy_q & ~sel_mask_s;
`endif
            end else begin
                busy_d = busy_d;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0; q1b_q <= '0; q2b_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i] <= '0; pc_q[i] <= '0; imm_q[i] <= '0; rob_q[i] <= '0;
                q1t_q[i] <= '0; q2t_q[i] <= '0; v1_q[i] <= '0; v2_q[i] <= '0;
`ifdef RS_AGE_SELECT_EN
                age_q[i] <= '0;
`endif
            end
            work_q <= 1'b0; out_op_q <= '0; out_pc_q <= '0; out_imm_q <= '0;
            out_rs1_q <= '0; out_rs2_q <= '0; out_rob_q <= '0;
        end else begin
            busy_q <= busy_d; q1b_q <= q1b_d; q2b_q <= q2b_d;
            op_q <= op_d; pc_q <= pc_d; imm_q <= imm_d; rob_q <= rob_d;
            q1t_q <= q1t_d; q2t_q <= q2t_d; v1_q <= v1_d; v2_q <= v2_d;
`ifdef RS_AGE_SELECT_EN
            age_q <= age_d;
`endif
            work_q <= work_d; out_op_q <= out_op_d; out_pc_q <= out_pc_d; out_imm_q <= out_imm_d;
            out_rs1_q <= out_rs1_d; out_rs2_q <= out_rs2_d; out_rob_q <= out_rob_d;
        end
    end

    assign full        = &busy_q;
    assign alu_work    = work_q;
    assign alu_op      = out_op_q;
    assign alu_pc      = out_pc_q;
    assign alu_imm     = out_imm_q;
    assign alu_rs1     = out_rs1_q;
    assign alu_rs2     = out_rs2_q;
    assign alu_rob_pos = out_rob_q;
endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: dispatch, wakeup, bypass, full, rollback, freeze, select order, async reset.
module tb_alu_rs;
    localparam logic [5:0] ADD = 6'd1;
    localparam logic [5:0] SUB = 6'd2;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, issue_valid;
    logic [5:0]  issue_op;
    logic [31:0] issue_pc, issue_imm, issue_v1, issue_v2;
    logic [3:0]  issue_rob_pos, issue_q1_tag, issue_q2_tag;
    logic        issue_q1_busy, issue_q2_busy;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [3:0]  alu_cdb_rob, lsb_cdb_rob;
    logic [31:0] alu_cdb_val, lsb_cdb_val;
    logic        full, alu_work;
    logic [5:0]  alu_op;
    logic [31:0] alu_pc, alu_imm, alu_rs1, alu_rs2;
    logic [3:0]  alu_rob_pos;
    int tests = 0;
    int fails = 0;

    alu_rs dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_pc(issue_pc), .issue_imm(issue_imm),
        .issue_rob_pos(issue_rob_pos), .issue_q1_busy(issue_q1_busy), .issue_q2_busy(issue_q2_busy),
        .issue_q1_tag(issue_q1_tag), .issue_q2_tag(issue_q2_tag), .issue_v1(issue_v1), .issue_v2(issue_v2),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
        .full(full), .alu_work(alu_work), .alu_op(alu_op), .alu_pc(alu_pc), .alu_imm(alu_imm),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rob_pos(alu_rob_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [5:0] op, input logic [3:0] rob, input logic b1, input logic [3:0] t1,
                       input logic [31:0] v1, input logic b2, input logic [3:0] t2, input logic [31:0] v2);
        issue_valid = 1'b1; issue_op = op; issue_rob_pos = rob; issue_pc = {28'd0, rob} << 2;
        issue_imm = 32'd0; issue_q1_busy = b1; issue_q1_tag = t1; issue_v1 = v1;
        issue_q2_busy = b2; issue_q2_tag = t2; issue_v2 = v2;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic alu_bcast(input logic [3:0] rob, input logic [31:0] val);
        alu_cdb_valid = 1'b1; alu_cdb_rob = rob; alu_cdb_val = val;
    endtask

    task automatic idle_cdb();
        alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue_valid = 1'b0;
        issue_op = 6'd0; issue_pc = 32'd0; issue_imm = 32'd0; issue_v1 = 32'd0; issue_v2 = 32'd0;
        issue_rob_pos = 4'd0; issue_q1_tag = 4'd0; issue_q2_tag = 4'd0;
        issue_q1_busy = 1'b0; issue_q2_busy = 1'b0;
        alu_cdb_valid = 1'b0; alu_cdb_rob = 4'd0; alu_cdb_val = 32'd0;
        lsb_cdb_valid = 1'b0; lsb_cdb_rob = 4'd0; lsb_cdb_val = 32'd0;
        tick(); tick();
        chk("rst_work", 32'(alu_work), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rs1", alu_rs1, 32'd0);
        rst = 1'b0;
        tick();

        // ADD both ready
        put(ADD, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
        chk("add_e0_work", 32'(alu_work), 32'd0);
        tick();
        chk("add_work", 32'(alu_work), 32'd1);
        chk("add_op", 32'(alu_op), 32'(ADD));
        chk("add_rs1", alu_rs1, 32'd5);
        chk("add_rs2", alu_rs2, 32'd7);
        chk("add_rob", 32'(alu_rob_pos), 32'd3);
        chk("add_pc", alu_pc, 32'd12);
        tick();
        chk("add_e2_work", 32'(alu_work), 32'd0);
        chk("add_hold_rs1", alu_rs1, 32'd5);

        // SUB waits on tag 6 from ALU bus
        put(SUB, 4'd4, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd3);
        tick();
        chk("sub_wait", 32'(alu_work), 32'd0);
        alu_bcast(4'd6, 32'h10);
        tick();
        idle_cdb();
        chk("sub_wake_edge", 32'(alu_work), 32'd0);
        tick();
        chk("sub_work", 32'(alu_work), 32'd1);
        chk("sub_rs1", alu_rs1, 32'h10);
        chk("sub_rs2", alu_rs2, 32'd3);
        chk("sub_rob", 32'(alu_rob_pos), 32'd4);
        chk("sub_op", 32'(alu_op), 32'(SUB));

        // issue bypass from LSB bus
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd9; lsb_cdb_val = 32'hFFFF_FFFF;
        put(ADD, 4'd5, 1'b0, 4'd0, 32'd1, 1'b1, 4'd9, 32'd0);
        idle_cdb();
        tick();
        chk("byp_work", 32'(alu_work), 32'd1);
        chk("byp_rs2", alu_rs2, 32'hFFFF_FFFF);
        chk("byp_rob", 32'(alu_rob_pos), 32'd5);
        tick();

        // fill all 16 entries, entry i waits on tag i
        for (int i = 0; i < 16; i++) begin
            put(ADD, 4'(i), 1'b1, 4'(i), 32'd0, 1'b0, 4'd0, 32'(i));
            if (i == 14) chk("full_at15", 32'(full), 32'd0);
        end
        chk("full_at16", 32'(full), 32'd1);
        put(ADD, 4'd14, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
        chk("drop_full", 32'(full), 32'd1);
        chk("drop_work", 32'(alu_work), 32'd0);
        alu_bcast(4'd7, 32'h77);
        tick();
        idle_cdb();
        chk("wake7_full", 32'(full), 32'd1);
        tick();
        chk("wake7_work", 32'(alu_work), 32'd1);
        chk("wake7_rob", 32'(alu_rob_pos), 32'd7);
        chk("wake7_rs1", alu_rs1, 32'h77);
        chk("wake7_rs2", alu_rs2, 32'd7);
        chk("after_full", 32'(full), 32'd0);
        tick();
        chk("drop_nodisp", 32'(alu_work), 32'd0);

        // rollback of the remaining entries, then of three fresh pending ones
        rollback = 1'b1; tick(); rollback = 1'b0;
        chk("rb1_full", 32'(full), 32'd0);
        put(ADD, 4'd1, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'd0);
        put(ADD, 4'd2, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd0);
        put(ADD, 4'd3, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd0);
        rollback = 1'b1;
        issue_valid = 1'b1; issue_q1_busy = 1'b0; issue_q2_busy = 1'b0;
        tick();
        rollback = 1'b0; issue_valid = 1'b0;
        chk("rb2_full", 32'(full), 32'd0);
        chk("rb2_work", 32'(alu_work), 32'd0);
        alu_bcast(4'd1, 32'd1); lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd2; lsb_cdb_val = 32'd2;
        tick();
        alu_bcast(4'd3, 32'd3); lsb_cdb_valid = 1'b0;
        tick();
        idle_cdb();
        chk("rb_nowork1", 32'(alu_work), 32'd0);
        tick();
        chk("rb_nowork2", 32'(alu_work), 32'd0);
        tick();
        chk("rb_nowork3", 32'(alu_work), 32'd0);

        // rdy=0 drops issue and freezes dispatch
        rdy = 1'b0;
        put(ADD, 4'd2, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 32'd9);
        rdy = 1'b1;
        tick();
        chk("rdy_drop", 32'(alu_work), 32'd0);
        put(ADD, 4'd12, 1'b0, 4'd0, 32'hA, 1'b0, 4'd0, 32'hB);
        rdy = 1'b0;
        tick();
        chk("rdy_freeze", 32'(alu_work), 32'd0);
        rdy = 1'b1;
        tick();
        chk("rdy_resume", 32'(alu_work), 32'd1);
        chk("rdy_rob", 32'(alu_rob_pos), 32'd12);
        tick();

        // ordering: entry 1 older than entry 0, both woken in the same cycle
        put(ADD, 4'd8, 1'b1, 4'd10, 32'd0, 1'b0, 4'd0, 32'd0);
        put(ADD, 4'd9, 1'b1, 4'd11, 32'd0, 1'b0, 4'd0, 32'd0);
        alu_bcast(4'd10, 32'd0);
        tick();
        idle_cdb();
        tick();
        chk("age_pre_rob", 32'(alu_rob_pos), 32'd8);
        put(ADD, 4'd10, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0);
        alu_bcast(4'd11, 32'h11); lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd12; lsb_cdb_val = 32'h12;
        tick();
        idle_cdb();
        tick();
`ifdef RS_AGE_SELECT_EN
        chk("age_first", 32'(alu_rob_pos), 32'd9);
        tick();
        chk("age_second", 32'(alu_rob_pos), 32'd10);
`else
        chk("age_first", 32'(alu_rob_pos), 32'd10);
        tick();
        chk("age_second", 32'(alu_rob_pos), 32'd9);
`endif
        chk("age_second_work", 32'(alu_work), 32'd1);
        tick();
        chk("age_done", 32'(alu_work), 32'd0);

        // asynchronous reset mid-operation
        put(SUB, 4'd13, 1'b0, 4'd0, 32'h55, 1'b0, 4'd0, 32'h66);
        tick();
        chk("pre_arst_work", 32'(alu_work), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_work", 32'(alu_work), 32'd0);
        chk("arst_rob", 32'(alu_rob_pos), 32'd0);
        chk("arst_rs1", alu_rs1, 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
